// File: rtl/pcpu_trace_buffer_if.sv
// Bundle of the trace buffer control, probe and readback signals.
// The master side (CPU top level / debug host) drives arming, probe data
// and readback selection; the slave side (the trace buffer) returns
// readback data and capture status.
interface pcpu_trace_buffer_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16
) ();

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      start;
  logic [CHANNELS*WIDTH-1:0] probe;
  logic                      probe_valid;
  logic                      trig;
  logic [AW:0]               post_count;
  logic [CW-1:0]             rd_ch;
  logic [AW-1:0]             rd_idx;
  logic [WIDTH-1:0]          rd_data;
  logic                      armed;
  logic                      triggered;
  logic                      done;
  logic [AW:0]               count;

  modport master (
    output start, probe, probe_valid, trig, post_count, rd_ch, rd_idx,
    input  rd_data, armed, triggered, done, count
  );

  modport slave (
    input  start, probe, probe_valid, trig, post_count, rd_ch, rd_idx,
    output rd_data, armed, triggered, done, count
  );

endinterface

// File: rtl/pcpu_trace_buffer.sv
// Triggered, multi-channel circular trace buffer for the pipelined CPU.
// Samples are captured while armed, the capture freezes a configurable
// number of samples after the trigger, and any channel of any held sample
// can be read back by age (index 0 = oldest) with one cycle of latency.
module pcpu_trace_buffer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  pcpu_trace_buffer_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    postLeft_q, postLeft_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic             armed_q, armed_d;
  logic             triggered_q, triggered_d;
  logic             done_q, done_d;
  logic             memWe;
  logic             cap;
  logic [AW-1:0]    postLoad;
  logic [AW-1:0]    oldest;
  logic [AW-1:0]    rdAddr;
  logic [SW-1:0]    rdWord;

  logic [SW-1:0]    mem [DEPTH];

  // A sample is eligible only while running and capturing.
  assign cap = enable_i & bus.probe_valid & ((state_q == ARMED) | (state_q == POST));

  // Post-trigger length is clamped so the trigger sample always survives in the ring.
  always_comb begin
    postLoad = bus.post_count[AW-1:0];
    if (bus.post_count > (AW+1)'(DEPTH - 1)) begin
      postLoad = AW'(DEPTH - 1);
    end
  end

  // Next-state logic: start has priority over capture, enable low holds everything.
  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    postLeft_d = postLeft_q;
    memWe      = 1'b0;
    if (enable_i) begin
      if (bus.start) begin
        state_d    = ARMED;
        wrPtr_d    = '0;
        count_d    = '0;
        postLeft_d = '0;
      end else begin
        case (state_q)
          ARMED: begin
            if (cap) begin
              memWe   = 1'b1;
              wrPtr_d = wrPtr_q + 1'b1;
              if (count_q != (AW+1)'(DEPTH)) begin
                count_d = count_q + 1'b1;
              end
              if (bus.trig) begin
                postLeft_d = postLoad;
                state_d    = (postLoad == '0) ? DONE : POST;
              end
            end
          end
          POST: begin
            if (cap) begin
              memWe      = 1'b1;
              wrPtr_d    = wrPtr_q + 1'b1;
              if (count_q != (AW+1)'(DEPTH)) begin
                count_d = count_q + 1'b1;
              end
              postLeft_d = postLeft_q - 1'b1;
              if (postLeft_q <= AW'(1)) begin
                postLeft_d = '0;
                state_d    = DONE;
              end
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  // Status flags are registered from the next state so they describe the state after the edge.
  always_comb begin
    armed_d     = (state_d == ARMED) | (state_d == POST);
    triggered_d = (state_d == POST) | (state_d == DONE);
    done_d      = (state_d == DONE);
  end

  // Once the ring has wrapped, the oldest sample sits at the write pointer.
  always_comb begin
    oldest = '0;
    if (count_q == (AW+1)'(DEPTH)) begin
      oldest = wrPtr_q;
    end
    rdAddr = oldest + bus.rd_idx;
    rdWord = mem[rdAddr];
  end

  // Channel select with masking of indices beyond the held sample count.
  always_comb begin
    rdData_d = '0;
    if ({1'b0, bus.rd_idx} < count_q) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.rd_ch == CW'(k)) begin
          rdData_d = rdWord[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Control and status registers; enable low freezes them all.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      count_q     <= '0;
      postLeft_q  <= '0;
      rdData_q    <= '0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (enable_i) begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      postLeft_q  <= postLeft_d;
      rdData_q    <= rdData_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  // Sample storage needs no reset; stale entries are hidden by the count check.
  always_ff @(posedge clk_i) begin
    if (memWe && !rst_i) begin
      mem[wrPtr_q] <= bus.probe;
    end
  end

  assign bus.rd_data   = rdData_q;
  assign bus.armed     = armed_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pcpu_trace_buffer.sv
// Self-checking bench for pcpu_trace_buffer (WIDTH=16, CHANNELS=4, DEPTH=8).
// A queue-based model of the captured history predicts every output each
// cycle; directed scenarios add literal expectations, then random traffic runs.
module tb_pcpu_trace_buffer;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 8;

  logic clk = 1'b0;
  logic rst;
  logic enable;

  int checks = 0;
  int errors = 0;

  pcpu_trace_buffer_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

  pcpu_trace_buffer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 armed, 2 post-trigger, 3 done; history oldest first.
  int          mState;
  int          mPostLeft;
  logic [63:0] hist[$];
  logic [15:0] expRd;

  function automatic logic [15:0] modelRead(input int ch, input int idx);
    logic [63:0] w;
    if (idx >= hist.size()) return 16'h0;
    w = hist[idx];
    return w[ch*16 +: 16];
  endfunction

  function automatic logic [63:0] mkProbe(input logic [15:0] v);
    if (v == 16'hDEAD) return {4{16'hDEAD}};
    return {v + 16'h0300, v + 16'h0200, v + 16'h0100, v};
  endfunction

  task automatic modelUpdate();
    int pl;
    if (rst) begin
      mState = 0; mPostLeft = 0; hist.delete(); expRd = 16'h0;
    end else if (enable) begin
      expRd = modelRead(int'(bus.rd_ch), int'(bus.rd_idx));
      if (bus.start) begin
        mState = 1; mPostLeft = 0; hist.delete();
      end else if (bus.probe_valid && (mState == 1 || mState == 2)) begin
        hist.push_back(bus.probe);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (mState == 1) begin
          if (bus.trig) begin
            pl = (int'(bus.post_count) > DEPTH - 1) ? DEPTH - 1 : int'(bus.post_count);
            if (pl == 0) mState = 3;
            else begin mState = 2; mPostLeft = pl; end
          end
        end else begin
          mPostLeft--;
          if (mPostLeft == 0) mState = 3;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("armed",     32'(bus.armed),     32'(mState == 1 || mState == 2));
    cmp("triggered", 32'(bus.triggered), 32'(mState == 2 || mState == 3));
    cmp("done",      32'(bus.done),      32'(mState == 3));
    cmp("count",     32'(bus.count),     32'(hist.size()));
    cmp("rd_data",   32'(bus.rd_data),   32'(expRd));
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    modelUpdate();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit en, input bit st, input bit vl, input bit tr,
                               input logic [15:0] v, input logic [4:0] pc);
    rst             = 1'b0;
    enable          = en;
    bus.start       = st;
    bus.probe_valid = vl;
    bus.trig        = tr;
    bus.probe       = mkProbe(v);
    bus.post_count  = pc[3:0];
    step();
  endtask

  task automatic readCheck(input int ch, input int idx, input logic [15:0] lit, input string name);
    bus.rd_ch  = 2'(ch);
    bus.rd_idx = 3'(idx);
    applyStimulus(1, 0, 0, 0, 16'h0, 5'd0);
    cmp(name, 32'(bus.rd_data), 32'(lit));
  endtask

  task automatic pinStatus(input bit a, input bit t, input bit d, input int c, input string name);
    cmp({name, ".armed"},     32'(bus.armed),     32'(a));
    cmp({name, ".triggered"}, 32'(bus.triggered), 32'(t));
    cmp({name, ".done"},      32'(bus.done),      32'(d));
    cmp({name, ".count"},     32'(bus.count),     32'(c));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    bus.start = 0; bus.probe = '0; bus.probe_valid = 0; bus.trig = 0;
    bus.post_count = '0; bus.rd_ch = '0; bus.rd_idx = '0;
    mState = 0; mPostLeft = 0; expRd = 0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      enable = 1'($urandom); bus.start = 1'($urandom); bus.probe_valid = 1'($urandom);
      bus.trig = 1'($urandom); bus.probe = {$urandom, $urandom};
      bus.post_count = 4'($urandom); bus.rd_ch = 2'($urandom); bus.rd_idx = 3'($urandom);
      step();
      pinStatus(0, 0, 0, 0, "reset");
      cmp("reset.rd_data", 32'(bus.rd_data), 32'h0);
    end
    for (int i = 0; i < DEPTH; i++) readCheck(0, i, 16'h0, "reset.read");

    // No wrap: trig on 3, two more samples
    applyStimulus(1, 1, 0, 0, 16'h0, 5'd2);
    for (int v = 1; v <= 5; v++) applyStimulus(1, 0, 1, v == 3, 16'(v), 5'd2);
    pinStatus(0, 1, 1, 5, "nowrap");
    for (int i = 0; i < DEPTH; i++) readCheck(0, i, (i < 5) ? 16'(i + 1) : 16'h0, "nowrap.read");

    // Wrap-around: trig on 13, then 14, 15
    applyStimulus(1, 1, 0, 0, 16'h0, 5'd2);
    for (int v = 1; v <= 15; v++) applyStimulus(1, 0, 1, v == 13, 16'(v), 5'd2);
    pinStatus(0, 1, 1, 8, "wrap");
    for (int i = 0; i < DEPTH; i++) readCheck(0, i, 16'(i + 8), "wrap.ch0");
    for (int i = 0; i < DEPTH; i++) readCheck(3, i, 16'(i + 8 + 16'h0300), "wrap.ch3");

    // Qualifiers: junk on disabled / invalid cycles, ignored trigger and start
    applyStimulus(1, 1, 0, 0, 16'h0, 5'd1);
    applyStimulus(1, 0, 1, 0, 16'd1, 5'd1);
    applyStimulus(0, 0, 1, 1, 16'hDEAD, 5'd0);
    applyStimulus(1, 0, 1, 0, 16'd2, 5'd1);
    applyStimulus(1, 0, 0, 1, 16'hDEAD, 5'd0);
    applyStimulus(1, 0, 1, 0, 16'd3, 5'd1);
    applyStimulus(0, 1, 1, 1, 16'hDEAD, 5'd0);
    pinStatus(1, 0, 0, 3, "qual.notrig");
    applyStimulus(1, 0, 1, 0, 16'd4, 5'd1);
    applyStimulus(1, 0, 1, 1, 16'd5, 5'd1);
    applyStimulus(1, 0, 0, 0, 16'hDEAD, 5'd1);
    applyStimulus(1, 0, 1, 0, 16'd6, 5'd1);
    pinStatus(0, 1, 1, 6, "qual");
    for (int i = 0; i < 6; i++) readCheck(0, i, 16'(i + 1), "qual.read");

    // Saturated post count: only DEPTH-1 samples follow the trigger
    applyStimulus(1, 1, 0, 0, 16'h0, 5'd10);
    for (int v = 1; v <= 14; v++) applyStimulus(1, 0, 1, v == 4, 16'(v), 5'd10);
    pinStatus(0, 1, 1, 8, "sat");
    readCheck(0, 0, 16'd4, "sat.idx0");
    readCheck(0, 7, 16'd11, "sat.idx7");

    // start and trig together: start wins
    applyStimulus(1, 1, 1, 1, 16'd20, 5'd0);
    pinStatus(1, 0, 0, 0, "starttrig");

    // start during POST, then rst during POST
    applyStimulus(1, 0, 1, 0, 16'd1, 5'd5);
    applyStimulus(1, 0, 1, 1, 16'd2, 5'd5);
    applyStimulus(1, 0, 1, 0, 16'd3, 5'd5);
    applyStimulus(1, 1, 1, 0, 16'd4, 5'd5);
    pinStatus(1, 0, 0, 0, "restart");
    applyStimulus(1, 0, 1, 1, 16'd5, 5'd5);
    applyStimulus(1, 0, 1, 0, 16'd6, 5'd5);
    rst = 1'b1; bus.start = 1'b1;
    step();
    pinStatus(0, 0, 0, 0, "midrst");
    cmp("midrst.rd_data", 32'(bus.rd_data), 32'h0);
    applyStimulus(1, 1, 0, 0, 16'h0, 5'd0);
    for (int v = 7; v <= 9; v++) applyStimulus(1, 0, 1, v == 9, 16'(v), 5'd0);
    pinStatus(0, 1, 1, 3, "postrst");
    readCheck(0, 0, 16'd7, "postrst.idx0");
    readCheck(2, 2, 16'd9 + 16'h0200, "postrst.idx2ch2");

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.rd_ch  = 2'($urandom);
      bus.rd_idx = 3'($urandom);
      applyStimulus(($urandom % 8) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                    ($urandom % 8) == 0, 16'($urandom), 5'($urandom_range(0, 15)));
      if (($urandom % 150) == 0) begin
        rst = 1'b1;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
